// File: rtl/simd_mult_pipe.sv
// Three-stage multiplier built from four half-width sub-multipliers: FULL, SUM and SIMD modes.
// Define SIMD_MULT_ACC_EN to build the result accumulator. Without it, acc is ignored.
module simd_mult_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic               a_sign,
    input  logic               b_sign,
    input  logic [1:0]         mode,
    input  logic               acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result_0,
    output logic [2*WIDTH-1:0] result_1
);

    localparam int unsigned L  = WIDTH / 2;
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned PW = 2 * L + 2;

    localparam logic [1:0] MODE_SUM  = 2'b01;
    localparam logic [1:0] MODE_SIMD = 2'b10;

    logic               en;
    logic               s1_valid_q;
    logic               s2_valid_q;
    logic               out_valid_q;
    logic [DW-1:0]      s1_a_q;
    logic [DW-1:0]      s1_b_q;
    logic               s1_sa_q;
    logic               s1_sb_q;
    logic [1:0]         s1_mode_q;
    logic [1:0]         s2_mode_q;
    logic [3:0][PW-1:0] s2_pp_q;
    logic [3:0][PW-1:0] pp_d;
    logic [DW-1:0]      res0_q;
    logic [DW-1:0]      res1_q;
    logic [DW-1:0]      res0_d;
    logic [DW-1:0]      res1_d;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign en        = ~out_valid_q | out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign result_0  = res0_q;
    assign result_1  = res1_q;

    // Valid chain: bubbles propagate as zeros and are never squeezed out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_sa_q   <= 1'b0;
            s1_sb_q   <= 1'b0;
            s1_mode_q <= 2'b00;
        end else if (en) begin
            s1_a_q    <= a;
            s1_b_q    <= b;
            s1_sa_q   <= a_sign;
            s1_sb_q   <= b_sign;
            s1_mode_q <= mode;
        end
    end

    logic               s1_full;
    logic [3:0][L-1:0]  op_a;
    logic [3:0][L-1:0]  op_b;
    logic [3:0]         sg_a;
    logic [3:0]         sg_b;
    logic [3:0][PW-1:0] ext_a;
    logic [3:0][PW-1:0] ext_b;

    // Sub-multiplier i takes lane i of a and b, except in FULL where the four units form the
    // cross products of the low operand halves with only the upper lanes sign-controlled.
    always_comb begin
        s1_full = (s1_mode_q != MODE_SUM) && (s1_mode_q != MODE_SIMD);
        for (int i = 0; i < 4; i++) begin
            op_a[i] = s1_a_q[i*L +: L];
            op_b[i] = s1_b_q[i*L +: L];
            sg_a[i] = s1_sa_q;
            sg_b[i] = s1_sb_q;
        end
        if (s1_full) begin
            op_a[0] = s1_a_q[0 +: L];
            op_b[0] = s1_b_q[0 +: L];
            sg_a[0] = 1'b0;
            sg_b[0] = 1'b0;
            op_a[1] = s1_a_q[L +: L];
            op_b[1] = s1_b_q[0 +: L];
            sg_a[1] = s1_sa_q;
            sg_b[1] = 1'b0;
            op_a[2] = s1_a_q[0 +: L];
            op_b[2] = s1_b_q[L +: L];
            sg_a[2] = 1'b0;
            sg_b[2] = s1_sb_q;
            op_a[3] = s1_a_q[L +: L];
            op_b[3] = s1_b_q[L +: L];
            sg_a[3] = s1_sa_q;
            sg_b[3] = s1_sb_q;
        end
        for (int i = 0; i < 4; i++) begin
            ext_a[i] = {{(L + 2){sg_a[i] & op_a[i][L-1]}}, op_a[i]};
            ext_b[i] = {{(L + 2){sg_b[i] & op_b[i][L-1]}}, op_b[i]};
            pp_d[i]  = $signed(ext_a[i]) * $signed(ext_b[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_pp_q   <= '0;
            s2_mode_q <= 2'b00;
        end else if (en) begin
            s2_pp_q   <= pp_d;
            s2_mode_q <= s1_mode_q;
        end
    end

    logic               s2_full;
    logic               s2_simd;
    logic [3:0][DW-1:0] ppx;
    logic [DW-1:0]      prod0;
    logic [DW-1:0]      prod1;

    // Partial products are exact signed values, so modulo-DW sums give the true product/sum.
    always_comb begin
        s2_simd = (s2_mode_q == MODE_SIMD);
        s2_full = (s2_mode_q != MODE_SUM) && !s2_simd;
        for (int i = 0; i < 4; i++) begin
            ppx[i] = {{(DW - PW){s2_pp_q[i][PW-1]}}, s2_pp_q[i]};
        end
        if (s2_simd) begin
            prod0 = {s2_pp_q[1][WIDTH-1:0], s2_pp_q[0][WIDTH-1:0]};
            prod1 = {s2_pp_q[3][WIDTH-1:0], s2_pp_q[2][WIDTH-1:0]};
        end else if (s2_full) begin
            prod0 = (ppx[3] << (2 * L)) + (ppx[2] << L) + (ppx[1] << L) + ppx[0];
            prod1 = '0;
        end else begin
            prod0 = ppx[0] + ppx[1];
            prod1 = ppx[2] + ppx[3];
        end
    end

`ifdef SIMD_MULT_ACC_EN
    logic s1_acc_q;
    logic s2_acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_acc_q <= 1'b0;
            s2_acc_q <= 1'b0;
        end else if (en) begin
            s1_acc_q <= acc;
            s2_acc_q <= s1_acc_q;
        end
    end

    // The held output doubles as the accumulator base; SIMD lanes wrap without carry.
    always_comb begin
        res0_d = prod0;
        res1_d = prod1;
        if (s2_acc_q) begin
            if (s2_simd) begin
                res0_d = {res0_q[DW-1:WIDTH] + prod0[DW-1:WIDTH],
                          res0_q[WIDTH-1:0] + prod0[WIDTH-1:0]};
                res1_d = {res1_q[DW-1:WIDTH] + prod1[DW-1:WIDTH],
                          res1_q[WIDTH-1:0] + prod1[WIDTH-1:0]};
            end else begin
                res0_d = res0_q + prod0;
                res1_d = res1_q + prod1;
            end
        end
    end
`else
    logic unused_acc;

    assign unused_acc = acc;
    assign res0_d     = prod0;
    assign res1_d     = prod1;
`endif

    // Only a real token rewrites the result; bubbles leave the last result in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res0_q <= '0;
            res1_q <= '0;
        end else if (en && s2_valid_q) begin
            res0_q <= res0_d;
            res1_q <= res1_d;
        end
    end

endmodule

// File: tb/tb_simd_mult_pipe.sv
// Directed bench for simd_mult_pipe: mode products, latency, stall/ordering, accumulate, reset.
module tb_simd_mult_pipe;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DW    = 2 * WIDTH;

`ifdef SIMD_MULT_ACC_EN
    localparam logic [DW-1:0] ACC_FULL_EXP = 32'd42;
    localparam logic [DW-1:0] ACC_SIMD_EXP = 32'h0000FC02;
`else
    localparam logic [DW-1:0] ACC_FULL_EXP = 32'd30;
    localparam logic [DW-1:0] ACC_SIMD_EXP = 32'h0000FE01;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          a_sign;
    logic          b_sign;
    logic [1:0]    mode;
    logic          acc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result_0;
    logic [DW-1:0] result_1;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];

    simd_mult_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .mode      (mode),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_0  (result_0),
        .result_1  (result_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic tsa,
                         input logic tsb, input logic [1:0] tm, input logic tacc);
        op_a     = ta;
        op_b     = tb;
        a_sign   = tsa;
        b_sign   = tsb;
        mode     = tm;
        acc      = tacc;
        in_valid = 1'b1;
    endtask

    // One token through an empty pipe: checks acceptance, 3-cycle latency and both results.
    task automatic run_one(input string tag, input logic [DW-1:0] ta, input logic [DW-1:0] tb,
                           input logic tsa, input logic tsb, input logic [1:0] tm,
                           input logic tacc, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        out_ready = 1'b1;
        drive(ta, tb, tsa, tsb, tm, tacc);
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_lat2"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_lat3"}, 32'(out_valid), 32'd1);
        check({tag, "_r0"}, result_0, e0);
        check({tag, "_r1"}, result_1, e1);
        tick();
    endtask

    task automatic drain(input int n);
        int got = 0;
        for (int c = 0; c < 20 && got < n; c++) begin
            if (out_valid) begin
                check($sformatf("drain%0d_r0", got), result_0, exp0_q.pop_front());
                check($sformatf("drain%0d_r1", got), result_1, exp1_q.pop_front());
                got++;
            end
            tick();
        end
        check("drain_count", 32'(got), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        a_sign    = 1'b0;
        b_sign    = 1'b0;
        mode      = 2'b00;
        acc       = 1'b0;
        repeat (2) tick();
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_r0", result_0, 32'd0);
        check("rst_r1", result_1, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_one("full_s", 32'h0000FFFF, 32'h00000002, 1'b1, 1'b1, 2'b00, 1'b0,
                32'hFFFFFFFE, 32'h0);
        run_one("full_u", 32'h0000FFFF, 32'h00000002, 1'b0, 1'b0, 2'b00, 1'b0,
                32'h0001FFFE, 32'h0);
        run_one("full_mix_m3", 32'h12348000, 32'h5678FFFF, 1'b1, 1'b0, 2'b11, 1'b0,
                32'h80008000, 32'h0);
        run_one("full_min", 32'h00008000, 32'h00008000, 1'b1, 1'b1, 2'b00, 1'b0,
                32'h40000000, 32'h0);
        run_one("sum_s", 32'h0000FF02, 32'h00000403, 1'b1, 1'b1, 2'b01, 1'b0,
                32'h00000002, 32'h0);
        run_one("sum_neg", 32'h80800000, 32'h7F7F0000, 1'b1, 1'b1, 2'b01, 1'b0,
                32'h0, 32'hFFFF8100);
        run_one("sum_u", 32'h80800000, 32'h7F7F0000, 1'b0, 1'b0, 2'b01, 1'b0,
                32'h0, 32'h00007F00);
        run_one("sum_u2", 32'hFFFF0302, 32'hFFFF0504, 1'b0, 1'b0, 2'b01, 1'b0,
                32'h00000017, 32'h0001FC02);
        run_one("simd_u", 32'h04030201, 32'h05050505, 1'b0, 1'b0, 2'b10, 1'b0,
                32'h000A0005, 32'h0014000F);
        run_one("simd_s", 32'hFF02FE7F, 32'h0302FF80, 1'b1, 1'b1, 2'b10, 1'b0,
                32'h0002C080, 32'hFFFD0004);

        // Three back-to-back tokens, then hold the output for four cycles.
        out_ready = 1'b1;
        drive(32'h04030201, 32'h05050505, 1'b0, 1'b0, 2'b10, 1'b0);
        exp0_q.push_back(32'h000A0005);
        exp1_q.push_back(32'h0014000F);
        tick();
        drive(32'h00000003, 32'h00000004, 1'b0, 1'b0, 2'b00, 1'b0);
        exp0_q.push_back(32'd12);
        exp1_q.push_back(32'd0);
        tick();
        drive(32'h02020101, 32'h03030101, 1'b0, 1'b0, 2'b01, 1'b0);
        exp0_q.push_back(32'd2);
        exp1_q.push_back(32'd12);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall%0d_ov", c), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d_rdy", c), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d_r0", c), result_0, 32'h000A0005);
            tick();
        end
        out_ready = 1'b1;
        drain(3);
        check("stall_tail_ov", 32'(out_valid), 32'd0);

        // Accumulate; idle cycles between tokens are bubbles that must not disturb the base.
        run_one("acc_base", 32'd3, 32'd4, 1'b0, 1'b0, 2'b00, 1'b0, 32'd12, 32'd0);
        run_one("acc_add", 32'd5, 32'd6, 1'b0, 1'b0, 2'b00, 1'b1, ACC_FULL_EXP, 32'd0);
        run_one("simd_base", 32'h000000FF, 32'h000000FF, 1'b0, 1'b0, 2'b10, 1'b0,
                32'h0000FE01, 32'd0);
        run_one("simd_wrap", 32'h000000FF, 32'h000000FF, 1'b0, 1'b0, 2'b10, 1'b1,
                ACC_SIMD_EXP, 32'd0);

        // Reset with two tokens in flight and a non-zero held result.
        out_ready = 1'b1;
        drive(32'd7, 32'd8, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        drive(32'd9, 32'd9, 1'b0, 1'b0, 2'b00, 1'b1);
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_ov", 32'(out_valid), 32'd0);
        check("midrst_r0", result_0, 32'd0);
        tick();
        check("midrst_hold_ov", 32'(out_valid), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_rdy", 32'(in_ready), 32'd1);
        repeat (3) tick();
        check("midrst_flush_ov", 32'(out_valid), 32'd0);
        run_one("post_rst", 32'd2, 32'd3, 1'b0, 1'b0, 2'b00, 1'b1, 32'd6, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simd_mult_pipe.md
SIMD_MULT_PIPE -- requirements
Module: simd_mult_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, full-mode operand width (even, >=4); lane width L = WIDTH/2.
REQ-002 SHALL provide ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample offered.
- in_ready  out  1  input sample accepted when in_valid & in_ready.
- a, b  in  2*WIDTH each  operand words.
- a_sign, b_sign  in  1 each  1 = operand lanes are two's complement.
- mode  in  2  00 FULL, 01 SUM, 10 SIMD, 11 treated as FULL.
- acc  in  1  accumulate this sample into the held result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result_0, result_1  out  2*WIDTH each  result words.

Function
REQ-003 SHALL sample a, b, a_sign, b_sign, mode and acc together on each accepted handshake and carry them as one token.
REQ-004 SHALL use three stages: operand register, partial-product register, sum/output register; latency SHALL be exactly 3 cycles from accept to out_valid with no stall.
REQ-005 SHALL advance all stages only when en = ~out_valid | out_ready; in_ready SHALL equal en; a stall SHALL freeze every stage, and tokens SHALL NOT be dropped, duplicated or reordered.
REQ-006 SHALL leave empty stages (bubbles) in place; bubbles are not squeezed out.
REQ-007 SHALL hold result_0/result_1 stable while out_valid=1 and out_ready=0.
REQ-008 FULL: result_0 = a[WIDTH-1:0] * b[WIDTH-1:0], full 2*WIDTH-bit product, each operand signed per its sign flag; result_1 = 0.
REQ-009 SUM: result_0 = a[L-1:0]*b[L-1:0] + a[WIDTH-1:L]*b[WIDTH-1:L]; result_1 is the same for a/b[2*WIDTH-1:WIDTH]; each sum is sign-extended to 2*WIDTH when either sign flag is set and zero-extended otherwise.
REQ-010 SIMD: four independent L x L products p_i of lane i (bits i*L+L-1:i*L); result_0 = {p1,p0}, result_1 = {p3,p2}, each p_i WIDTH bits; there is no carry between lane fields.
REQ-011 SHALL build all modes from four L x L sub-multipliers with per-lane sign control; an upper lane is signed only if its sign flag is set, and lower lanes in FULL are unsigned.
REQ-012 Accumulate (when compiled in): if the token's acc=1, the new result SHALL equal the held output result plus the computed result, added field-wise per the token's mode (FULL/SUM: 2*WIDTH fields; SIMD: WIDTH fields), wrapping modulo field width; if acc=0, the held result is replaced.
REQ-013 The accumulator base SHALL be the most recently produced result, whether or not it was consumed; a bubble SHALL NOT alter it.

Reset
REQ-014 Asserting reset SHALL immediately clear all stage valids, out_valid=0, result_0=result_1=0, and the accumulator base=0; in-flight tokens SHALL be discarded.
REQ-015 After deassertion in_ready SHALL be 1, and the first accepted token SHALL appear 3 cycles later.

Configuration
REQ-016 Macro SIMD_MULT_ACC_EN: when defined, REQ-012/013 apply; when undefined, acc is ignored, no accumulator adder is built, and results are the plain products.

Verification
REQ-017 FULL signed: a=0x0000FFFF, b=0x00000002, signs 1/1 -> result_0=0xFFFFFFFE, result_1=0, out_valid exactly 3 cycles after accept.
REQ-018 FULL unsigned, same operands -> result_0=0x0001FFFE.
REQ-019 SUM signed: a=0x0000FF02, b=0x00000403 -> result_0=0x00000002 (6-4), result_1=0.
REQ-020 SIMD unsigned: a=0x04030201, b=0x05050505 -> result_0=0x000A0005, result_1=0x0014000F.
REQ-021 Stall: three back-to-back tokens, out_ready=0 for 4 cycles once out_valid=1 -> in_ready=0, result held, then all three results delivered in order with none lost.
REQ-022 Accumulate (macro defined): FULL unsigned 3*4 acc=0, then 5*6 acc=1 -> 12, then 42; macro undefined -> 12, then 30; reset asserted mid-stream -> outputs 0 immediately, and the next token is not accumulated onto pre-reset data.
